ahb_spi_master_fifo: RTL and testbench

- AHB-Lite slave SPI master, next generation of the single-buffer SPI peripheral.
- Adds parametrised TX/RX byte FIFOs, programmable SPI clock divider, all four CPOL/CPHA modes, MSB/LSB-first order, and a parametrised slave-select count.
- Sits on the AHB-Lite bus beside the other peripherals and drives external SPI slaves such as the Nexys4 display.

---
 rtl/ahb_spi_master_fifo_if.sv | 22 ++
 rtl/ahb_spi_master_fifo.sv | 226 ++++++++++++++++++++++
 tb/tb_ahb_spi_master_fifo.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_spi_master_fifo_if.sv
// AHB-Lite slave-side bus bundle for the FIFO-based SPI master.
interface ahb_spi_master_fifo_if;
    logic        HSEL;
    logic        HREADY;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADYOUT;

    modport master (
        output HSEL, HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
        input  HRDATA, HREADYOUT
    );

    modport slave (
        input  HSEL, HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
        output HRDATA, HREADYOUT
    );
endinterface

// File: rtl/ahb_spi_master_fifo.sv
// AHB-Lite SPI master with TX/RX byte FIFOs, programmable clock divider,
// all four CPOL/CPHA modes, selectable bit order and software-driven slave selects.
module ahb_spi_master_fifo #(
    parameter int unsigned NUM_SS   = 32,
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned RX_DEPTH = 8,
    parameter int unsigned DIV_W    = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_spi_master_fifo_if.slave bus,
    input  logic                 SPI_MISO_i,
    output logic                 SPI_MOSI_o,
    output logic [NUM_SS-1:0]    SPI_SS_o,
    output logic                 SPI_CLK_o
);
    localparam int unsigned TAW = $clog2(TX_DEPTH);
    localparam int unsigned RAW = $clog2(RX_DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StLoad  = 2'd1;
    localparam logic [1:0] StShift = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrStatus = 3'd1;
    localparam logic [2:0] AddrSs     = 3'd2;
    localparam logic [2:0] AddrDiv    = 3'd3;
    localparam logic [2:0] AddrTx     = 3'd4;
    localparam logic [2:0] AddrRx     = 3'd5;

    logic              dp_valid_q, dp_write_q;
    logic [2:0]        dp_addr_q;
    logic              wr_en, rd_en, sts_wr;
    logic [3:0]        ctrl_q;
    logic [NUM_SS-1:0] ss_q;
    logic [DIV_W-1:0]  div_q;
    logic              tx_ovf_q, rx_ovf_q, tx_ovf_set, rx_ovf_set;

    logic [7:0]   tx_mem_q [TX_DEPTH];
    logic [TAW-1:0] tx_wptr_q, tx_rptr_q;
    logic [TAW:0] tx_cnt_q;
    logic         tx_wr_req, tx_push, tx_pop, tx_empty, tx_full;

    logic [7:0]   rx_mem_q [RX_DEPTH];
    logic [RAW-1:0] rx_wptr_q, rx_rptr_q;
    logic [RAW:0] rx_cnt_q;
    logic         rx_push, rx_pop, rx_empty, rx_full;

    logic [1:0]       state_q;
    logic [DIV_W-1:0] div_cnt_q, div_l_q;
    logic [3:0]       half_q;
    logic [7:0]       txb_q, rxb_q;
    logic             cpol_l_q, cpha_l_q, lsbf_l_q, sclk_q, mosi_q;
    logic             half_end, leading, busy;
    logic [2:0]       bit_idx;

    logic [31:0] rdata, ss_rd, div_rd;
    logic        unused_bus;

    assign wr_en  = dp_valid_q & dp_write_q;
    assign rd_en  = dp_valid_q & ~dp_write_q;
    assign sts_wr = wr_en && (dp_addr_q == AddrStatus);

    assign tx_empty = (tx_cnt_q == '0);
    assign tx_full  = (tx_cnt_q == (TAW + 1)'(TX_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == (RAW + 1)'(RX_DEPTH));

    // A push into a full TX FIFO is still accepted when the engine pops in the same cycle.
    assign tx_pop     = (state_q == StLoad);
    assign tx_wr_req  = wr_en && (dp_addr_q == AddrTx);
    assign tx_push    = tx_wr_req && (!tx_full || tx_pop);
    assign tx_ovf_set = tx_wr_req && tx_full && !tx_pop;

    assign rx_pop     = rd_en && (dp_addr_q == AddrRx) && !rx_empty;
    assign rx_push    = (state_q == StDone) && (!rx_full || rx_pop);
    assign rx_ovf_set = (state_q == StDone) && rx_full && !rx_pop;

    assign busy     = (state_q != StIdle);
    assign half_end = (state_q == StShift) && (div_cnt_q == div_l_q);
    assign leading  = ~half_q[0];
    assign bit_idx  = half_q[3:1];

    function automatic logic pick_bit(input logic [7:0] b, input logic [2:0] i,
                                      input logic lsbf);
        return lsbf ? b[i] : b[3'd7 - i];
    endfunction

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 3'd0;
            ctrl_q     <= 4'd0;
            ss_q       <= '1;
            div_q      <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
        end else begin
            dp_valid_q <= bus.HSEL & bus.HREADY & bus.HTRANS[1];
            dp_write_q <= bus.HWRITE;
            dp_addr_q  <= bus.HADDR[4:2];
            if (wr_en) begin
                case (dp_addr_q)
                    AddrCtrl: ctrl_q <= bus.HWDATA[3:0];
                    AddrSs:   ss_q   <= bus.HWDATA[NUM_SS-1:0];
                    AddrDiv:  div_q  <= bus.HWDATA[DIV_W-1:0];
                    default: ;
                endcase
            end
            // A new overflow in the same cycle as a clear wins.
            tx_ovf_q <= (tx_ovf_q & ~(sts_wr & bus.HWDATA[5])) | tx_ovf_set;
            rx_ovf_q <= (rx_ovf_q & ~(sts_wr & bus.HWDATA[6])) | rx_ovf_set;
        end
    end

    always_ff @(posedge HCLK) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= bus.HWDATA[7:0];
        if (rx_push) rx_mem_q[rx_wptr_q] <= rxb_q;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            rx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + TAW'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + TAW'(1);
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + (TAW + 1)'(1);
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - (TAW + 1)'(1);
            if (rx_push) rx_wptr_q <= rx_wptr_q + RAW'(1);
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + RAW'(1);
            if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + (RAW + 1)'(1);
            else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - (RAW + 1)'(1);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q   <= StIdle;
            div_cnt_q <= '0;
            div_l_q   <= '0;
            half_q    <= 4'd0;
            txb_q     <= 8'd0;
            rxb_q     <= 8'd0;
            cpol_l_q  <= 1'b0;
            cpha_l_q  <= 1'b0;
            lsbf_l_q  <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    sclk_q <= ctrl_q[1];
                    if (ctrl_q[0] && !tx_empty) state_q <= StLoad;
                end
                StLoad: begin
                    txb_q     <= tx_mem_q[tx_rptr_q];
                    rxb_q     <= 8'd0;
                    cpol_l_q  <= ctrl_q[1];
                    cpha_l_q  <= ctrl_q[2];
                    lsbf_l_q  <= ctrl_q[3];
                    div_l_q   <= div_q;
                    sclk_q    <= ctrl_q[1];
                    div_cnt_q <= '0;
                    half_q    <= 4'd0;
                    // CPHA=0 needs the first bit on MOSI before the first leading edge.
                    if (!ctrl_q[2]) mosi_q <= pick_bit(tx_mem_q[tx_rptr_q], 3'd0, ctrl_q[3]);
                    state_q   <= StShift;
                end
                StShift: begin
                    if (half_end) begin
                        div_cnt_q <= '0;
                        sclk_q    <= ~sclk_q;
                        half_q    <= half_q + 4'd1;
                        if (leading == cpha_l_q) begin
                            mosi_q <= pick_bit(txb_q, cpha_l_q ? bit_idx : bit_idx + 3'd1,
                                               lsbf_l_q);
                        end else begin
                            rxb_q[lsbf_l_q ? bit_idx : 3'd7 - bit_idx] <= SPI_MISO_i;
                        end
                        if (half_q == 4'd15) state_q <= StDone;
                    end else begin
                        div_cnt_q <= div_cnt_q + DIV_W'(1);
                    end
                end
                default: begin
                    state_q <= (ctrl_q[0] && !tx_empty) ? StLoad : StIdle;
                end
            endcase
        end
    end

    always_comb begin
        ss_rd  = '0;
        div_rd = '0;
        ss_rd[NUM_SS-1:0] = ss_q;
        div_rd[DIV_W-1:0] = div_q;
        rdata = '0;
        if (rd_en) begin
            case (dp_addr_q)
                AddrCtrl:   rdata[3:0] = ctrl_q;
                AddrStatus: rdata[6:0] = {rx_ovf_q, tx_ovf_q, busy, rx_full, rx_empty,
                                          tx_full, tx_empty};
                AddrSs:     rdata = ss_rd;
                AddrDiv:    rdata = div_rd;
                AddrRx:     if (!rx_empty) rdata[7:0] = rx_mem_q[rx_rptr_q];
                default: ;
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign SPI_CLK_o     = sclk_q;
    assign SPI_MOSI_o    = mosi_q;
    assign SPI_SS_o      = ss_q;

    assign unused_bus = ^{bus.HSIZE, bus.HTRANS[0], bus.HADDR[31:5], bus.HADDR[1:0],
                          bus.HWDATA};
endmodule

// File: tb/tb_ahb_spi_master_fifo.sv
// Randomised bench for ahb_spi_master_fifo: a queue-based reference model plus an
// SPI slave monitor that decodes MOSI per mode and can drive a MISO bit stream.
module tb_ahb_spi_master_fifo;
    localparam int unsigned NUM_SS   = 32;
    localparam int unsigned TX_DEPTH = 8;
    localparam int unsigned RX_DEPTH = 8;

    logic              HCLK = 1'b0;
    logic              HRESET;
    logic              SPI_MISO_i, SPI_MOSI_o, SPI_CLK_o;
    logic [NUM_SS-1:0] SPI_SS_o;
    logic              loopback = 1'b1;
    logic              miso_drv = 1'b0;

    ahb_spi_master_fifo_if bus_if();

    ahb_spi_master_fifo #(
        .NUM_SS   (NUM_SS),
        .TX_DEPTH (TX_DEPTH),
        .RX_DEPTH (RX_DEPTH),
        .DIV_W    (8)
    ) u_dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .bus        (bus_if),
        .SPI_MISO_i (SPI_MISO_i),
        .SPI_MOSI_o (SPI_MOSI_o),
        .SPI_SS_o   (SPI_SS_o),
        .SPI_CLK_o  (SPI_CLK_o)
    );

    assign SPI_MISO_i = loopback ? SPI_MOSI_o : miso_drv;

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // SPI slave monitor
    logic       mon_en = 1'b0;
    logic       m_cpol = 1'b0, m_cpha = 1'b0, m_lsbf = 1'b0;
    logic       sclk_prev = 1'b0;
    logic [7:0] mbits;
    int         nbits = 0;
    int         pidx = 0;
    logic [63:0] pattern = 64'h0102030405060708;
    logic [7:0] mon_bytes[$];
    int         rise_q[$];

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    initial begin
        forever begin
            @(negedge HCLK);
            if (mon_en && (SPI_CLK_o !== sclk_prev)) begin
                logic lead;
                lead = (SPI_CLK_o != m_cpol);
                if (SPI_CLK_o) rise_q.push_back(cyc);
                if (lead != m_cpha) begin
                    mbits = {mbits[6:0], SPI_MOSI_o};
                    nbits++;
                    if (nbits == 8) begin
                        mon_bytes.push_back(m_lsbf ? rev8(mbits) : mbits);
                        nbits = 0;
                    end
                end
                if (lead && m_cpha && !loopback && pidx < 64) begin
                    miso_drv = pattern[63 - pidx];
                    pidx++;
                end
            end
            sclk_prev = SPI_CLK_o;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
        @(posedge HCLK); #1;
        bus_if.HSEL = 1'b1; bus_if.HTRANS = 2'b10; bus_if.HWRITE = 1'b1;
        bus_if.HADDR = {27'd0, off}; bus_if.HSIZE = 3'b010;
        @(posedge HCLK); #1;
        bus_if.HSEL = 1'b0; bus_if.HTRANS = 2'b00; bus_if.HWRITE = 1'b0;
        bus_if.HWDATA = data;
        @(posedge HCLK); #1;
    endtask

    task automatic bus_read(input logic [4:0] off, output logic [31:0] data);
        @(posedge HCLK); #1;
        bus_if.HSEL = 1'b1; bus_if.HTRANS = 2'b10; bus_if.HWRITE = 1'b0;
        bus_if.HADDR = {27'd0, off}; bus_if.HSIZE = 3'b010;
        @(posedge HCLK); #1;
        bus_if.HSEL = 1'b0; bus_if.HTRANS = 2'b00;
        data = bus_if.HRDATA;
    endtask

    task automatic read_check(input string tag, input logic [4:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(off, d);
        check_eq(tag, d, exp);
    endtask

    function automatic logic [31:0] exp_status(input int txc, input int rxc, input bit busy,
                                               input bit txo, input bit rxo);
        return {25'd0, rxo, txo, busy, rxc == RX_DEPTH, rxc == 0, txc == TX_DEPTH, txc == 0};
    endfunction

    logic [3:0] mode_bits = 4'd0;

    task automatic set_mode(input bit cpol, input bit cpha, input bit lsbf, input int div);
        mon_en = 1'b0;
        mode_bits = {lsbf, cpha, cpol, 1'b0};
        bus_write(5'h00, {28'd0, mode_bits});
        bus_write(5'h0C, div);
        m_cpol = cpol; m_cpha = cpha; m_lsbf = lsbf;
        mon_bytes.delete(); rise_q.delete(); nbits = 0; pidx = 0;
        repeat (2) @(posedge HCLK);
        #1 mon_en = 1'b1;
    endtask

    task automatic set_en(input bit en);
        bus_write(5'h00, {28'd0, mode_bits[3:1], en});
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic [31:0] w;
        w = $urandom;
        w[7:0] = b;
        bus_write(5'h10, w);
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] s;
        bit          done = 0;
        for (int k = 0; k < 1500 && !done; k++) begin
            bus_read(5'h04, s);
            if (!s[4] && s[0]) done = 1;
        end
        check_eq({tag, "_idle"}, done, 1);
    endtask

    initial begin
        logic [31:0] d, w;
        logic [7:0]  sent[$];
        int          n, acc;
        bit          cpol, cpha, lsbf, got_edges;

        bus_if.HSEL = 0; bus_if.HREADY = 1; bus_if.HADDR = 0; bus_if.HWRITE = 0;
        bus_if.HSIZE = 0; bus_if.HTRANS = 0; bus_if.HWDATA = 0;
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Reset state
        check_eq("rst_sclk", SPI_CLK_o, 0);
        check_eq("rst_mosi", SPI_MOSI_o, 0);
        check_eq("rst_ss_pins", SPI_SS_o, 32'hFFFF_FFFF);
        check_eq("rst_hreadyout", bus_if.HREADYOUT, 1);
        check_eq("rst_hrdata_idle", bus_if.HRDATA, 0);
        read_check("rst_status", 5'h04, 32'h05);
        read_check("rst_ss", 5'h08, 32'hFFFF_FFFF);
        read_check("rst_ctrl", 5'h00, 0);
        read_check("rst_div", 5'h0C, 0);

        // SS register, write-only / unmapped reads
        w = $urandom;
        bus_write(5'h08, w);
        read_check("ss_rb", 5'h08, w);
        check_eq("ss_pins", SPI_SS_o, w);
        bus_write(5'h08, 32'hFFFF_FFFF);
        bus_write(5'h18, 32'hDEAD_BEEF);
        read_check("unmapped_rd", 5'h18, 0);
        read_check("txdata_rd", 5'h10, 0);
        read_check("rx_empty_rd", 5'h14, 0);

        // Mode 0 loopback, DIV=1
        loopback = 1'b1;
        set_mode(0, 0, 0, 1);
        sent.delete();
        sent.push_back(8'hA5);
        sent.push_back(8'($urandom));
        foreach (sent[i]) push_byte(sent[i]);
        set_en(1);
        wait_idle("m0");
        check_eq("m0_mosi0", mon_bytes.size() > 0 ? mon_bytes[0] : 8'hxx, 8'hA5);
        check_eq("m0_mosi1", mon_bytes.size() > 1 ? mon_bytes[1] : 8'hxx, sent[1]);
        check_eq("m0_rises", rise_q.size(), 16);
        check_eq("m0_period", rise_q.size() > 1 ? rise_q[1] - rise_q[0] : -1, 4);
        check_eq("m0_bytetime", rise_q.size() > 8 ? rise_q[8] - rise_q[0] : -1, 34);
        read_check("m0_rx0", 5'h14, 8'hA5);
        read_check("m0_rx1", 5'h14, sent[1]);
        read_check("m0_status", 5'h04, exp_status(0, 0, 0, 0, 0));
        set_en(0);

        // Mode 3, LSB first, DIV=0, slave drives a fixed pattern
        loopback = 1'b0;
        set_mode(1, 1, 1, 0);
        check_eq("m3_idle_hi", SPI_CLK_o, 1);
        sent.delete();
        for (int i = 0; i < 4; i++) sent.push_back(8'($urandom));
        foreach (sent[i]) push_byte(sent[i]);
        set_en(1);
        wait_idle("m3");
        check_eq("m3_idle_hi_after", SPI_CLK_o, 1);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("m3_mosi%0d", i), mon_bytes.size() > i ? mon_bytes[i] : 8'hxx,
                     sent[i]);
            read_check($sformatf("m3_rx%0d", i), 5'h14, rev8(pattern[63 - 8*i -: 8]));
        end
        read_check("m3_rx_empty", 5'h04, exp_status(0, 0, 0, 0, 0));
        set_en(0);
        loopback = 1'b1;

        // TX overflow
        set_mode(0, 0, 0, 0);
        sent.delete();
        for (int i = 0; i < TX_DEPTH + 1; i++) begin
            sent.push_back(8'($urandom));
            push_byte(sent[i]);
        end
        read_check("txovf_status", 5'h04, exp_status(TX_DEPTH, 0, 0, 1, 0));
        bus_write(5'h04, 32'h20);
        read_check("txovf_clear", 5'h04, exp_status(TX_DEPTH, 0, 0, 0, 0));
        set_en(1);
        wait_idle("txovf");
        check_eq("txovf_count", mon_bytes.size(), TX_DEPTH);
        for (int i = 0; i < TX_DEPTH; i++)
            read_check($sformatf("txovf_rx%0d", i), 5'h14, sent[i]);
        set_en(0);

        // RX overflow
        set_mode(1'($urandom), 1'($urandom), 1'($urandom), 0);
        set_en(1);
        sent.delete();
        for (int i = 0; i < RX_DEPTH + 1; i++) begin
            sent.push_back(8'($urandom));
            push_byte(sent[i]);
            wait_idle("rxovf_tx");
        end
        read_check("rxovf_status", 5'h04, exp_status(0, RX_DEPTH, 0, 0, 1));
        for (int i = 0; i < RX_DEPTH; i++)
            read_check($sformatf("rxovf_rx%0d", i), 5'h14, sent[i]);
        read_check("rxovf_sticky", 5'h04, exp_status(0, 0, 0, 0, 1));
        bus_write(5'h04, 32'h40);
        read_check("rxovf_clear", 5'h04, exp_status(0, 0, 0, 0, 0));
        set_en(0);

        // Randomised modes, dividers and burst lengths
        for (int it = 0; it < 8; it++) begin
            cpol = it[0];
            cpha = it[1];
            lsbf = 1'($urandom_range(0, 1));
            n    = $urandom_range(1, TX_DEPTH + 2);
            acc  = (n > TX_DEPTH) ? TX_DEPTH : n;
            set_mode(cpol, cpha, lsbf, $urandom_range(0, 3));
            sent.delete();
            for (int i = 0; i < n; i++) begin
                sent.push_back(8'($urandom));
                push_byte(sent[i]);
            end
            read_check($sformatf("r%0d_status_pre", it), 5'h04,
                       exp_status(acc, 0, 0, n > TX_DEPTH, 0));
            set_en(1);
            wait_idle($sformatf("r%0d", it));
            check_eq($sformatf("r%0d_count", it), mon_bytes.size(), acc);
            for (int i = 0; i < acc; i++) begin
                check_eq($sformatf("r%0d_mosi%0d", it, i),
                         mon_bytes.size() > i ? mon_bytes[i] : 8'hxx, sent[i]);
                read_check($sformatf("r%0d_rx%0d", it, i), 5'h14, sent[i]);
            end
            check_eq($sformatf("r%0d_sclk_idle", it), SPI_CLK_o, cpol);
            read_check($sformatf("r%0d_status_post", it), 5'h04,
                       exp_status(0, 0, 0, n > TX_DEPTH, 0));
            bus_write(5'h04, 32'h60);
            set_en(0);
        end

        // Reset during bit 3 of a byte
        set_mode(0, 0, 0, 3);
        push_byte(8'($urandom));
        push_byte(8'($urandom));
        set_en(1);
        got_edges = 0;
        for (int k = 0; k < 500 && !got_edges; k++) begin
            @(posedge HCLK);
            if (rise_q.size() >= 4) got_edges = 1;
        end
        check_eq("midrst_reached_bit3", got_edges, 1);
        mon_en = 1'b0;
        #1 HRESET = 1'b1;
        @(posedge HCLK); #1;
        check_eq("midrst_sclk", SPI_CLK_o, 0);
        check_eq("midrst_mosi", SPI_MOSI_o, 0);
        HRESET = 1'b0;
        read_check("midrst_status", 5'h04, 32'h05);
        read_check("midrst_ctrl", 5'h00, 0);
        repeat (100) @(posedge HCLK);
        read_check("midrst_no_rx", 5'h04, 32'h05);
        read_check("midrst_rxdata", 5'h14, 0);
        check_eq("midrst_sclk_late", SPI_CLK_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
